// File: rtl/led_pkg.sv
// Shared constants and types for the LED sharing IPs: LED bank width, arbiter
// state encoding, default time-base settings and the PWM dimmer width.
package led_pkg;

  localparam int LED_W          = 8;
  localparam int PWM_W          = 4;
  localparam int DEF_TICK_DIV   = 50_000_000;
  localparam int DEF_HOLD_TICKS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } led_state_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running prescaler producing a one-cycle Tick every TICK_DIV clocks.
// Reusable time base for LED IPs; TICK_DIV=1 yields Tick high every cycle.
module led_tick_prescaler #(
  parameter int TICK_DIV = led_pkg::DEF_TICK_DIV
) (
  input  logic Clk,
  input  logic Reset,
  output logic Tick
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      Tick <= 1'b1;
    end else begin
      cnt  <= cnt + 32'd1;
      Tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 8 user LEDs between NUM_REQ requesters with a
// tick-based minimum hold. Define LED_SHARE_DIM_EN to add the Duty PWM dimmer.
module led_share_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [LED_W*NUM_REQ-1:0] Pattern,
`ifdef LED_SHARE_DIM_EN
  input  logic [PWM_W-1:0]         Duty,
`endif
  output logic [NUM_REQ-1:0]       Grant,
  output logic [LED_W-1:0]         Leds,
  output logic                     Busy,
  output logic                     Tick
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_REQ - 1);

  led_state_t         state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [LED_W-1:0]   leds_nxt;
  logic [PTR_W:0]     pick_idle, pick_pre;
  logic               dim_on;
  logic               hold_done;

  // First set bit searching upward from ptr+1 (mod NUM_REQ); {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PTR_W-1:0]   from);
    logic [PTR_W:0] res;
    int j;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = int'(from) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) res = {1'b1, PTR_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  led_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .Clk  (Clk),
    .Reset(Reset),
    .Tick (Tick)
  );

`ifdef LED_SHARE_DIM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign dim_on = (pwm_cnt < Duty);
`else
  assign dim_on = 1'b1;
`endif

  assign pick_idle = rr_pick(Req, ptr);
  assign pick_pre  = rr_pick(Req & ~Grant, ptr);
  // The tick that brings the hold count to HOLD_TICKS is itself the pre-emption point.
  assign hold_done = Tick && (hold_cnt >= HOLD_LAST);
  assign Busy      = (state == OWN);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    grant_nxt = Grant;
    leds_nxt  = '0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_idle[PTR_W]) begin
          state_nxt = OWN;
          ptr_nxt   = pick_idle[PTR_W-1:0];
          grant_nxt = one_hot(pick_idle[PTR_W-1:0]);
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (!Req[ptr]) begin
          // Owner drop beats a coinciding pre-emption.
          state_nxt = IDLE;
          grant_nxt = '0;
          hold_nxt  = '0;
        end else begin
          leds_nxt = Pattern[int'(ptr)*LED_W +: LED_W] & {LED_W{dim_on}};
          if (hold_done && pick_pre[PTR_W]) begin
            ptr_nxt   = pick_pre[PTR_W-1:0];
            grant_nxt = one_hot(pick_pre[PTR_W-1:0]);
            hold_nxt  = '0;
          end else if (Tick && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      hold_cnt <= '0;
      Grant    <= '0;
      Leds     <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      Grant    <= grant_nxt;
      Leds     <= leds_nxt;
    end
  end

endmodule
